// File: rtl/brtgt_sched.sv
// brtgt_sched: shared branch/jump target unit for the two decode slots.
// Round-robin grant between the slots, a capture register (stage 1), and an
// output register (stage 2). The target arithmetic sits between the two stages.
// Valid/ready backpressure is supported, and kill flushes all in-flight work.
module brtgt_sched #(
  parameter int ADDR_LEN = 32,
  parameter int INSN_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                kill,
  input  logic                req1_valid,
  input  logic [INSN_LEN-1:0] req1_inst,
  input  logic [ADDR_LEN-1:0] req1_pc,
  input  logic [ADDR_LEN-1:0] req1_rs1,
  output logic                req1_ready,
  input  logic                req2_valid,
  input  logic [INSN_LEN-1:0] req2_inst,
  input  logic [ADDR_LEN-1:0] req2_pc,
  input  logic [ADDR_LEN-1:0] req2_rs1,
  output logic                req2_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_LEN-1:0] out_target,
  output logic                out_src,
  output logic [1:0]          out_kind
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // B-format immediate, sign-extended to address width
  function automatic logic signed [ADDR_LEN-1:0] imm_b(input logic [INSN_LEN-1:0] i);
    logic signed [12:0] imm;
    imm = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    return {{(ADDR_LEN-13){imm[12]}}, imm};
  endfunction

  // J-format immediate, sign-extended to address width
  function automatic logic signed [ADDR_LEN-1:0] imm_j(input logic [INSN_LEN-1:0] i);
    logic signed [20:0] imm;
    imm = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    return {{(ADDR_LEN-21){imm[20]}}, imm};
  endfunction

  // I-format immediate, sign-extended to address width
  function automatic logic signed [ADDR_LEN-1:0] imm_i(input logic [INSN_LEN-1:0] i);
    logic signed [11:0] imm;
    imm = i[31:20];
    return {{(ADDR_LEN-12){imm[11]}}, imm};
  endfunction

  // Target address. All sums wrap modulo 2^ADDR_LEN.
  function automatic logic [ADDR_LEN-1:0] calc_target(input logic [INSN_LEN-1:0] i,
                                                      input logic [ADDR_LEN-1:0] pc,
                                                      input logic [ADDR_LEN-1:0] rs1);
    logic [ADDR_LEN-1:0] sum;
    case (i[6:0])
      OP_BRANCH: sum = pc + imm_b(i);
      OP_JAL:    sum = pc + imm_j(i);
      OP_JALR: begin
        sum = rs1 + imm_i(i);
        sum = {sum[ADDR_LEN-1:1], 1'b0};
      end
      default:   sum = pc + ADDR_LEN'(4);
    endcase
    return sum;
  endfunction

  // Control-transfer kind: 00 none, 01 branch, 10 JAL, 11 JALR
  function automatic logic [1:0] calc_kind(input logic [6:0] op);
    case (op)
      OP_BRANCH: return 2'b01;
      OP_JAL:    return 2'b10;
      OP_JALR:   return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

  // Stage 1 capture register. The valid bit is vld_p1; the data is not reset.
  logic                vld_p1;
  logic [INSN_LEN-1:0] inst_p1;
  logic [ADDR_LEN-1:0] pc_p1;
  logic [ADDR_LEN-1:0] rs1_p1;
  logic                src_p1;

  // Round-robin pointer. 0 gives slot 1 priority, 1 gives slot 2 priority.
  logic rr_ptr;

  logic grant1, grant2;
  logic s2_free, s1_open, s1_adv, accept;

  // Grant, readiness and pipeline-advance decode
  always_comb begin
    grant1     = req1_valid & (~req2_valid | ~rr_ptr);
    grant2     = req2_valid & (~req1_valid |  rr_ptr);
    s2_free    = ~out_valid | out_ready;
    s1_open    = ~vld_p1 | s2_free;
    s1_adv     = vld_p1 & s2_free;
    req1_ready = grant1 & s1_open & ~kill;
    req2_ready = grant2 & s1_open & ~kill;
    accept     = req1_ready | req2_ready;
  end

  // ---- stage 0 -> stage 1: request capture ----
  // Stage 1 valid and the RR pointer. Kill wins over accept and advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      rr_ptr <= 1'b0;
    end else if (kill) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      rr_ptr <= req1_ready;
    end else if (s1_adv) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage 1 data. It is loaded only on an accept, which kill already blocks.
  always_ff @(posedge clk) begin
    if (accept) begin
      inst_p1 <= req1_ready ? req1_inst : req2_inst;
      pc_p1   <= req1_ready ? req1_pc   : req2_pc;
      rs1_p1  <= req1_ready ? req1_rs1  : req2_rs1;
      src_p1  <= req2_ready;
    end
  end

  // ---- stage 1 -> stage 2: target computation into output register ----
  // Output register. out_* hold while stalled and are zeroed at reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_target <= '0;
      out_src    <= 1'b0;
      out_kind   <= 2'b00;
    end else if (kill) begin
      out_valid  <= 1'b0;
    end else if (s1_adv) begin
      out_valid  <= 1'b1;
      out_target <= calc_target(inst_p1, pc_p1, rs1_p1);
      out_src    <= src_p1;
      out_kind   <= calc_kind(inst_p1[6:0]);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_brtgt_sched.sv
// Testbench for brtgt_sched. It runs directed vectors, hand sequences for
// contention, backpressure, kill and reset, and then a randomized run that is
// compared against a queue-based reference model.
module tb_brtgt_sched;

  logic        clk, reset, kill;
  logic        req1_valid, req2_valid, req1_ready, req2_ready;
  logic [31:0] req1_inst, req1_pc, req1_rs1, req2_inst, req2_pc, req2_rs1;
  logic        out_valid, out_ready, out_src;
  logic [31:0] out_target;
  logic [1:0]  out_kind;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] JAL20 = 32'h020000EF;

  brtgt_sched #(.ADDR_LEN(32), .INSN_LEN(32)) dut (
    .clk(clk), .reset(reset), .kill(kill),
    .req1_valid(req1_valid), .req1_inst(req1_inst), .req1_pc(req1_pc),
    .req1_rs1(req1_rs1), .req1_ready(req1_ready),
    .req2_valid(req2_valid), .req2_inst(req2_inst), .req2_pc(req2_pc),
    .req2_rs1(req2_rs1), .req2_ready(req2_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_target(out_target),
    .out_src(out_src), .out_kind(out_kind)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        slot;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] exp_t;
    logic [1:0]  exp_k;
  } vec_t;

  typedef struct {
    logic [31:0] t;
    logic        src;
    logic [1:0]  k;
    logic        in_out;
  } item_t;

  vec_t  vecs[7];
  item_t q[$];

  task automatic chk_b(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic set_req(input logic slot, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] rs1);
    if (!slot) begin
      req1_valid = 1'b1; req1_inst = inst; req1_pc = pc; req1_rs1 = rs1;
    end else begin
      req2_valid = 1'b1; req2_inst = inst; req2_pc = pc; req2_rs1 = rs1;
    end
  endtask

  // Reference target/kind, computed from immediate field weights with integer arithmetic
  function automatic void ref_calc(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] rs1, output logic [31:0] t,
                                   output logic [1:0] k);
    int imm;
    imm = 0;
    case (inst[6:0])
      7'h63: begin
        if (inst[31]) imm = -4096;
        imm += 2048 * int'(inst[7]) + 32 * int'(inst[30:25]) + 2 * int'(inst[11:8]);
        t = pc + imm; k = 2'b01;
      end
      7'h6F: begin
        if (inst[31]) imm = -(1 << 20);
        imm += 4096 * int'(inst[19:12]) + 2048 * int'(inst[20]) + 2 * int'(inst[30:21]);
        t = pc + imm; k = 2'b10;
      end
      7'h67: begin
        if (inst[31]) imm = -2048;
        imm += int'(inst[30:20]);
        t = (rs1 + imm) & 32'hFFFF_FFFE; k = 2'b11;
      end
      default: begin
        t = pc + 32'd4; k = 2'b00;
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 3))
      0: op = 7'h63;
      1: op = 7'h6F;
      2: op = 7'h67;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  logic        p1, p2, pri, exp_ov, has_s1, s2f, s1o, g1, g2, e1, e2;
  logic [31:0] pi1, pp1, pr1, pi2, pp2, pr2;
  item_t       it;

  initial begin
    vecs[0] = '{slot: 1'b0, inst: 32'h020000EF, pc: 32'h100, rs1: 32'h0, exp_t: 32'h120, exp_k: 2'b10};
    vecs[1] = '{slot: 1'b1, inst: 32'hFE000EE3, pc: 32'h0, rs1: 32'h0, exp_t: 32'hFFFFFFFC, exp_k: 2'b01};
    vecs[2] = '{slot: 1'b0, inst: 32'h00328067, pc: 32'h500, rs1: 32'h1000, exp_t: 32'h1002, exp_k: 2'b11};
    vecs[3] = '{slot: 1'b1, inst: 32'h00000013, pc: 32'hFFFFFFFC, rs1: 32'h0, exp_t: 32'h0, exp_k: 2'b00};
    vecs[4] = '{slot: 1'b0, inst: 32'hFF9FF06F, pc: 32'h2000, rs1: 32'h0, exp_t: 32'h1FF8, exp_k: 2'b10};
    vecs[5] = '{slot: 1'b1, inst: 32'hFFF000E7, pc: 32'h0, rs1: 32'h10, exp_t: 32'hE, exp_k: 2'b11};
    vecs[6] = '{slot: 1'b0, inst: 32'h00001863, pc: 32'h400, rs1: 32'h0, exp_t: 32'h410, exp_k: 2'b01};

    clk = 0; reset = 1; kill = 0; out_ready = 1;
    req1_valid = 0; req1_inst = 0; req1_pc = 0; req1_rs1 = 0;
    req2_valid = 0; req2_inst = 0; req2_pc = 0; req2_rs1 = 0;
    repeat (2) @(negedge clk);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_w("rst_out_target", out_target, 32'h0);
    chk_b("rst_out_src", out_src, 1'b0);
    chk_w("rst_out_kind", {30'b0, out_kind}, 32'h0);
    chk_b("rst_ready1", req1_ready, 1'b0);
    chk_b("rst_ready2", req2_ready, 1'b0);
    reset = 0;

    // Contention: both slots valid for 4 cycles. Grants go 1,2,1,2 and results come out in that order.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk_b("cont_out_valid", out_valid, 1'b1);
        chk_b("cont_out_src", out_src, ((c - 2) % 2) == 1);
        chk_w("cont_out_target", out_target,
              ((((c - 2) % 2) == 1) ? 32'h2000 : 32'h1000) + 32'(16 * (c - 2)) + 32'h20);
      end
      if (c < 4) begin
        set_req(1'b0, JAL20, 32'h1000 + 32'(16 * c), 32'h0);
        set_req(1'b1, JAL20, 32'h2000 + 32'(16 * c), 32'h0);
        #1;
        chk_b("cont_ready1", req1_ready, (c % 2) == 0);
        chk_b("cont_ready2", req2_ready, (c % 2) == 1);
      end else begin
        req1_valid = 0; req2_valid = 0;
      end
    end

    // Backpressure: out_ready stays low until the pipe is full, then released
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      req1_valid = 0; req2_valid = 0;
      case (c)
        0: begin set_req(1'b0, JAL20, 32'h3000, 32'h0); #1 chk_b("bp_ready1_a", req1_ready, 1'b1); end
        1: begin set_req(1'b1, JAL20, 32'h4000, 32'h0); #1 chk_b("bp_ready2_b", req2_ready, 1'b1); end
        2, 3, 4: begin
          chk_b("bp_hold_valid", out_valid, 1'b1);
          chk_w("bp_hold_target", out_target, 32'h3020);
          chk_b("bp_hold_src", out_src, 1'b0);
          set_req(1'b0, JAL20, 32'h5000, 32'h0);
          #1;
          chk_b("bp_full_ready1", req1_ready, 1'b0);
          chk_b("bp_full_ready2", req2_ready, 1'b0);
        end
        5: begin
          chk_w("bp_a_target", out_target, 32'h3020);
          set_req(1'b0, JAL20, 32'h5000, 32'h0);
          #1 chk_b("bp_resume_ready1", req1_ready, 1'b1);
        end
        6: begin chk_w("bp_b_target", out_target, 32'h4020); chk_b("bp_b_src", out_src, 1'b1); end
        7: begin chk_w("bp_c_target", out_target, 32'h5020); chk_b("bp_c_valid", out_valid, 1'b1); end
        default: chk_b("bp_drained", out_valid, 1'b0);
      endcase
    end

    // Kill with both stages full and both slots pending
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req1_valid = 0; req2_valid = 0;
      case (c)
        0: begin out_ready = 0; set_req(1'b0, JAL20, 32'h6000, 32'h0); #1 chk_b("kl_ready_d", req1_ready, 1'b1); end
        1: begin set_req(1'b0, JAL20, 32'h7000, 32'h0); #1 chk_b("kl_ready_e", req1_ready, 1'b1); end
        2: begin
          chk_w("kl_full_target", out_target, 32'h6020);
          set_req(1'b0, JAL20, 32'h8000, 32'h0); set_req(1'b1, JAL20, 32'h9000, 32'h0);
          #1 chk_b("kl_full_ready", req1_ready | req2_ready, 1'b0);
        end
        3: begin
          chk_b("kl_pre_valid", out_valid, 1'b1);
          kill = 1;
          set_req(1'b0, JAL20, 32'h8000, 32'h0); set_req(1'b1, JAL20, 32'h9000, 32'h0);
          out_ready = 1;
          #1;
          chk_b("kl_ready1", req1_ready, 1'b0);
          chk_b("kl_ready2", req2_ready, 1'b0);
        end
        4: begin
          kill = 0;
          chk_b("kl_out_cleared", out_valid, 1'b0);
          set_req(1'b0, JAL20, 32'h8000, 32'h0); set_req(1'b1, JAL20, 32'h9000, 32'h0);
          #1;
          chk_b("kl_rr_ready1", req1_ready, 1'b0);
          chk_b("kl_rr_ready2", req2_ready, 1'b1);
        end
        5: chk_b("kl_s1_empty", out_valid, 1'b0);
        6: begin
          chk_b("kl_g_valid", out_valid, 1'b1);
          chk_b("kl_g_src", out_src, 1'b1);
          chk_w("kl_g_target", out_target, 32'h9020);
        end
        default: chk_b("kl_drained", out_valid, 1'b0);
      endcase
    end

    // Directed decode vectors. Check the accept, the latency, and the target/kind/src.
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      req1_valid = 0; req2_valid = 0;
      set_req(vecs[v].slot, vecs[v].inst, vecs[v].pc, vecs[v].rs1);
      #1 chk_b($sformatf("vec%0d_ready", v), vecs[v].slot ? req2_ready : req1_ready, 1'b1);
      @(negedge clk);
      req1_valid = 0; req2_valid = 0;
      chk_b($sformatf("vec%0d_lat", v), out_valid, 1'b0);
      @(negedge clk);
      chk_b($sformatf("vec%0d_valid", v), out_valid, 1'b1);
      chk_w($sformatf("vec%0d_target", v), out_target, vecs[v].exp_t);
      chk_w($sformatf("vec%0d_kind", v), {30'b0, out_kind}, {30'b0, vecs[v].exp_k});
      chk_b($sformatf("vec%0d_src", v), out_src, vecs[v].slot);
    end

    // Reset asserted mid-stream with both stages full
    @(negedge clk);
    out_ready = 0;
    set_req(1'b0, JAL20, 32'hA000, 32'h0);
    @(negedge clk);
    req1_valid = 0;
    set_req(1'b1, JAL20, 32'hB000, 32'h0);
    @(negedge clk);
    req2_valid = 0;
    chk_w("mr_pre_target", out_target, 32'hA020);
    #2 reset = 1;
    #1;
    chk_b("mr_out_valid", out_valid, 1'b0);
    chk_w("mr_out_target", out_target, 32'h0);
    chk_b("mr_ready1", req1_ready, 1'b0);
    chk_b("mr_ready2", req2_ready, 1'b0);
    @(negedge clk);
    reset = 0; out_ready = 1;
    repeat (2) begin
      @(negedge clk);
      chk_b("mr_no_partial", out_valid, 1'b0);
    end
    set_req(1'b0, JAL20, 32'h0, 32'h0); set_req(1'b1, JAL20, 32'h0, 32'h0);
    #1;
    chk_b("mr_first_ready1", req1_ready, 1'b1);
    chk_b("mr_first_ready2", req2_ready, 1'b0);
    #1 req1_valid = 0; req2_valid = 0;

    // Randomized run against the reference model
    pri = 0; p1 = 0; p2 = 0; q.delete();
    pi1 = 0; pp1 = 0; pr1 = 0; pi2 = 0; pp2 = 0; pr2 = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      exp_ov = (q.size() > 0) && q[0].in_out;
      chk_b("rnd_out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk_w("rnd_out_target", out_target, q[0].t);
        chk_b("rnd_out_src", out_src, q[0].src);
        chk_w("rnd_out_kind", {30'b0, out_kind}, {30'b0, q[0].k});
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1; pi1 = rand_inst(); pp1 = $urandom(); pr1 = $urandom();
      end
      if (!p2 && $urandom_range(0, 9) < 6) begin
        p2 = 1; pi2 = rand_inst(); pp2 = $urandom(); pr2 = $urandom();
      end
      kill = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      req1_valid = p1; req1_inst = pi1; req1_pc = pp1; req1_rs1 = pr1;
      req2_valid = p2; req2_inst = pi2; req2_pc = pp2; req2_rs1 = pr2;
      #1;
      has_s1 = (q.size() > 0) && !q[q.size()-1].in_out;
      s2f = !exp_ov || out_ready;
      s1o = !has_s1 || s2f;
      g1 = p1 && (!p2 || !pri);
      g2 = p2 && (!p1 || pri);
      e1 = g1 && s1o && !kill;
      e2 = g2 && s1o && !kill;
      chk_b("rnd_ready1", req1_ready, e1);
      chk_b("rnd_ready2", req2_ready, e2);
      @(posedge clk);
      if (kill) begin
        q.delete();
      end else begin
        if (exp_ov && out_ready) void'(q.pop_front());
        if ((q.size() > 0) && !q[q.size()-1].in_out && s2f) q[q.size()-1].in_out = 1'b1;
        if (e1 || e2) begin
          if (e1) ref_calc(pi1, pp1, pr1, it.t, it.k);
          else    ref_calc(pi2, pp2, pr2, it.t, it.k);
          it.src = e2; it.in_out = 1'b0;
          q.push_back(it);
          pri = e1;
          if (e1) p1 = 0;
          else    p2 = 0;
        end
      end
    end

    @(negedge clk);
    kill = 0; req1_valid = 0; req2_valid = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/brtgt_sched.md
Name: brtgt_sched

Overview:
- Shares one branch/jump target-computation unit between the two decode slots of the 2-wide front end.
- Arbitrates requests round-robin and decodes the control-transfer immediate (B/J/I formats).
- Computes the target in a 2-stage pipeline with valid/ready backpressure and a flush (kill) input.
- Sits between decode and the branch unit / fetch redirect logic.

Parameters:
- ADDR_LEN, 32, width of PC, rs1 operand and target.
- INSN_LEN, 32, instruction width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- kill  in  1  flush all in-flight work (mispredict recovery).
- req1_valid  in  1  slot-1 request.
- req1_inst  in  INSN_LEN  slot-1 instruction.
- req1_pc  in  ADDR_LEN  slot-1 PC.
- req1_rs1  in  ADDR_LEN  slot-1 rs1 value; JALR only.
- req1_ready  out  1  slot-1 accepted this cycle.
- req2_valid, req2_inst, req2_pc, req2_rs1, req2_ready: same as slot 1, for slot 2.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_target  out  ADDR_LEN  computed target.
- out_src  out  1  0 = slot 1, 1 = slot 2.
- out_kind  out  2  00 non-control, 01 conditional branch, 10 JAL, 11 JALR.

Behaviour:
- Reset (async, active-high):
  - s1_valid = 0, out_valid = 0, out_target = 0, out_src = 0, out_kind = 00.
  - RR pointer = 0 (slot 1 has priority).
- Stage 1 (capture register): holds the granted inst, pc, rs1 and src.
- Stage 2 (output register): holds out_*.
- Advance and accept conditions:
  - s2_free = ~out_valid | out_ready.
  - s1 advances when s1_valid & s2_free.
  - s1_open = ~s1_valid | s2_free.
- Grant (combinational):
  - Only one valid: grant that slot.
  - Both valid: grant the slot selected by the RR pointer.
- Ready:
  - reqN_ready = grantN & s1_open & ~kill.
  - Ready may depend on valid; a requester must not wait for ready before asserting valid.
- RR pointer: on any accept, it points to the non-granted slot. It is unchanged when there is no accept or when kill is high.
- Latency: an accept at edge k gives out_valid after edge k+1 (two registered stages). Full throughput of one result per cycle when out_ready is held high.
- Target arithmetic, computed in the s1→s2 transfer, modulo 2^ADDR_LEN (wrap, no overflow flag):
  - BRANCH (opcode 1100011): pc + sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - JAL (1101111): pc + sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - JALR (1100111): (rs1 + sext(inst[31:20])) with bit 0 forced to 0.
  - Any other opcode: pc + 4, out_kind = 00.
- Hold: while out_valid & ~out_ready, all out_* stay stable and s1 stalls.
- Kill:
  - At the next edge, clear s1_valid and out_valid.
  - Suppress new accepts that cycle (ready = 0).
  - Kill takes precedence over simultaneous accept, advance or drain.
  - out_target/out_src/out_kind may keep stale values while out_valid = 0.
- Reset asserted mid-operation: all state returns immediately to reset values; no partial result is emitted after release.
- Data registers with valid = 0 are don't-care, except out_* at reset (zeroed).

Test Plan:
- Reset and idle:
  - Assert reset mid-stream with both stages full → out_valid = 0, out_target = 0 and both readies 0 while no requests.
  - After release, the first grant goes to slot 1.
- JAL:
  - req1 inst = 0x020000EF (jal x1,+0x20), pc = 0x100, accepted at edge k.
  - out_valid after edge k+1, out_target = 0x120, out_kind = 10, out_src = 0.
- Negative branch wrap:
  - req2 inst = 0xFE000EE3 (beq x0,x0,-4), pc = 0x0.
  - out_target = 0xFFFFFFFC, out_kind = 01, out_src = 1.
- JALR LSB clear:
  - req1 inst = 0x00328067 (jalr x0,3(x5)), rs1 = 0x1000.
  - out_target = 0x1002, out_kind = 11.
- Contention and backpressure:
  - Both requesters valid for 4 cycles with out_ready = 1 → grants 1,2,1,2; results emerge in the same order.
  - Drop out_ready for 3 cycles → out_* hold, both readies 0 once s1 is full; resumes without loss or duplication.
- Kill:
  - Kill with both stages valid and both requests pending → next cycle out_valid = 0, s1 empty, no accept that cycle, RR pointer unchanged.
  - Following cycle, the granted slot is accepted normally.
